// File: rtl/matrix_ctrl_pkg.sv
// Shared types and defaults for the banked matrix address controller.
// Column-major reads exist only when MATRIX_CTRL_TRANSPOSE_EN is defined.
package matrix_ctrl_pkg;

  typedef enum logic {
    ORDER_ROW_MAJOR = 1'b0,
    ORDER_COL_MAJOR = 1'b1
  } order_e;

  localparam int DEF_NUM_BANKS = 16;
  localparam int DEF_ROW_W     = 10;
  localparam int DEF_COL_W     = 10;
  localparam int DEF_BANK_AW   = 16;
  localparam int DEF_RD_LAT    = 1;

  // Smallest n with (1 << n) >= value; usable in parameter expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_2d_banked.sv
// Two-dimensional (row, col) element counter with limits latched at matrix start.
// The column-major walk is built only under MATRIX_CTRL_TRANSPOSE_EN.
module counter_2d_banked
  import matrix_ctrl_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  order_e           i_order,
  input  logic [ROW_W-1:0] i_max_row,
  input  logic [COL_W-1:0] i_max_col,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_max_row;
  logic [COL_W-1:0] r_max_col;

  logic             w_at_origin;
  logic [ROW_W-1:0] w_max_row;
  logic [COL_W-1:0] w_max_col;
  logic             w_row_end;
  logic             w_col_end;
  logic [ROW_W-1:0] w_nxt_row;
  logic [COL_W-1:0] w_nxt_col;

  // At (0,0) the live configuration applies, so the very first access
  // (including a 1x1 matrix) already sees the limits it will latch.
  assign w_at_origin = (r_row == '0) && (r_col == '0);
  assign w_max_row   = w_at_origin ? i_max_row : r_max_row;
  assign w_max_col   = w_at_origin ? i_max_col : r_max_col;
  assign w_row_end   = (r_row == w_max_row);
  assign w_col_end   = (r_col == w_max_col);
  assign o_last      = w_row_end && w_col_end;
  assign o_row       = r_row;
  assign o_col       = r_col;

`ifdef MATRIX_CTRL_TRANSPOSE_EN
  order_e r_order;
  order_e w_order;
  assign w_order = w_at_origin ? i_order : r_order;
`else
  logic w_unused_order;
  assign w_unused_order = i_order;
`endif

  always_comb begin
    w_nxt_row = r_row;
    w_nxt_col = r_col;
    if (w_col_end) begin
      w_nxt_col = '0;
      w_nxt_row = w_row_end ? '0 : r_row + ROW_W'(1);
    end else begin
      w_nxt_col = r_col + COL_W'(1);
    end
`ifdef MATRIX_CTRL_TRANSPOSE_EN
    if (w_order == ORDER_COL_MAJOR) begin
      if (w_row_end) begin
        w_nxt_row = '0;
        w_nxt_col = w_col_end ? '0 : r_col + COL_W'(1);
      end else begin
        w_nxt_row = r_row + ROW_W'(1);
        w_nxt_col = r_col;
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_max_row <= '0;
      r_max_col <= '0;
`ifdef MATRIX_CTRL_TRANSPOSE_EN
      r_order   <= ORDER_ROW_MAJOR;
`endif
    end else if (i_inc) begin
      if (w_at_origin) begin
        r_max_row <= i_max_row;
        r_max_col <= i_max_col;
`ifdef MATRIX_CTRL_TRANSPOSE_EN
        r_order   <= i_order;
`endif
      end
      r_row <= w_nxt_row;
      r_col <= w_nxt_col;
    end
  end

endmodule

// File: rtl/matrix_ctrl_banked.sv
// Banked matrix RAM address controller: write-priority arbitration, bank decode,
// done pulses and read-valid delay line. Optional macro: MATRIX_CTRL_TRANSPOSE_EN.
module matrix_ctrl_banked
  import matrix_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int BANK_AW   = DEF_BANK_AW,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 we,
  input  logic                 re,
  input  logic                 transpose,
  input  logic [ROW_W-1:0]     max_row_count,
  input  logic [COL_W-1:0]     max_col_count,
  output logic [NUM_BANKS-1:0] ram_sel,
  output logic [BANK_AW-1:0]   a,
  output logic [NUM_BANKS-1:0] we_out,
  output logic                 re_grant,
  output logic                 rd_valid,
  output logic                 wr_done,
  output logic                 rd_done
);

  localparam int BS_W = clog2_f(NUM_BANKS);

  if (BANK_AW != ROW_W + COL_W - BS_W) begin : g_bad_aw
    $error("matrix_ctrl_banked: BANK_AW must equal ROW_W+COL_W-log2(NUM_BANKS)");
  end
  if ((NUM_BANKS < 2) || ((1 << BS_W) != NUM_BANKS)) begin : g_bad_banks
    $error("matrix_ctrl_banked: NUM_BANKS must be a power of 2 and >= 2");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("matrix_ctrl_banked: RD_LAT must be >= 1");
  end

  logic [ROW_W-1:0]  w_wr_row;
  logic [COL_W-1:0]  w_wr_col;
  logic              w_wr_last;
  logic [ROW_W-1:0]  w_rd_row;
  logic [COL_W-1:0]  w_rd_col;
  logic              w_rd_last;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [BS_W-1:0]   w_bank;
  logic              w_active;
  order_e            w_rd_order;
  logic [RD_LAT-1:0] r_rd_pipe;

`ifdef MATRIX_CTRL_TRANSPOSE_EN
  assign w_rd_order = transpose ? ORDER_COL_MAJOR : ORDER_ROW_MAJOR;
`else
  logic w_unused_transpose;
  assign w_unused_transpose = transpose;
  assign w_rd_order         = ORDER_ROW_MAJOR;
`endif

  // Writes win; a read presented alongside a write is stalled and not counted.
  assign re_grant = re & ~we;
  assign w_active = we | re;

  counter_2d_banked #(.ROW_W(ROW_W), .COL_W(COL_W)) u_wr_cnt (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_inc     (we),
    .i_order   (ORDER_ROW_MAJOR),
    .i_max_row (max_row_count),
    .i_max_col (max_col_count),
    .o_row     (w_wr_row),
    .o_col     (w_wr_col),
    .o_last    (w_wr_last)
  );

  counter_2d_banked #(.ROW_W(ROW_W), .COL_W(COL_W)) u_rd_cnt (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_inc     (re_grant),
    .i_order   (w_rd_order),
    .i_max_row (max_row_count),
    .i_max_col (max_col_count),
    .o_row     (w_rd_row),
    .o_col     (w_rd_col),
    .o_last    (w_rd_last)
  );

  assign w_row  = we ? w_wr_row : w_rd_row;
  assign w_col  = we ? w_wr_col : w_rd_col;
  // Top row bits pick the bank; the rest of the row plus the column form the bank address.
  assign w_bank = w_row[ROW_W-1 -: BS_W];

  assign ram_sel = w_active ? (NUM_BANKS'(1) << w_bank) : '0;
  assign a       = w_active ? BANK_AW'({w_row[ROW_W-BS_W-1:0], w_col}) : '0;
  assign we_out  = we ? ram_sel : '0;
  assign wr_done = we & w_wr_last;
  assign rd_done = re_grant & w_rd_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= re_grant;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  assign rd_valid = r_rd_pipe[RD_LAT-1];

endmodule

// File: tb/tb_matrix_ctrl_banked.sv
// Directed bench for matrix_ctrl_banked (16 banks, 10x10 counters, RD_LAT = 3).
// Expected order of transposed reads follows MATRIX_CTRL_TRANSPOSE_EN.
module tb_matrix_ctrl_banked;

  localparam int RD_LAT = 3;

  logic        CLK;
  logic        RST;
  logic        we;
  logic        re;
  logic        transpose;
  logic [9:0]  max_row_count;
  logic [9:0]  max_col_count;
  logic [15:0] ram_sel;
  logic [15:0] a;
  logic [15:0] we_out;
  logic        re_grant;
  logic        rd_valid;
  logic        wr_done;
  logic        rd_done;

  int          n_cmp;
  int          n_err;
  string       g_name;
  logic [RD_LAT-1:0] exp_pipe;

  matrix_ctrl_banked #(
    .NUM_BANKS (16),
    .ROW_W     (10),
    .COL_W     (10),
    .BANK_AW   (16),
    .RD_LAT    (RD_LAT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .we            (we),
    .re            (re),
    .transpose     (transpose),
    .max_row_count (max_row_count),
    .max_col_count (max_col_count),
    .ram_sel       (ram_sel),
    .a             (a),
    .we_out        (we_out),
    .re_grant      (re_grant),
    .rd_valid      (rd_valid),
    .wr_done       (wr_done),
    .rd_done       (rd_done)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", g_name, tag, got, exp);
    end
  endtask

  // hand-derived mapping for 16 banks, ROW_W = 10: bank = row[9:6], a = {row[5:0], col}
  function automatic logic [15:0] map_sel(input int row);
    return 16'(1 << (row >> 6));
  endfunction

  function automatic logic [15:0] map_a(input int row, input int col);
    return 16'(((row & 63) << 10) | col);
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    exp_pipe = '0;
  endtask

  // One cycle: drive strobes, check the combinational response and rd_valid, then clock.
  task automatic step(input logic w, input logic r, input logic [15:0] e_sel,
                      input logic [15:0] e_a, input logic e_wd, input logic e_rd);
    logic e_grant;
    e_grant = r & ~w;
    we = w;
    re = r;
    #1;
    check("ram_sel",  32'(ram_sel),  32'(e_sel));
    check("a",        32'(a),        32'(e_a));
    check("we_out",   32'(we_out),   w ? 32'(e_sel) : 32'd0);
    check("re_grant", 32'(re_grant), 32'(e_grant));
    check("wr_done",  32'(wr_done),  32'(e_wd));
    check("rd_done",  32'(rd_done),  32'(e_rd));
    check("rd_valid", 32'(rd_valid), 32'(exp_pipe[RD_LAT-1]));
    @(posedge CLK);
    exp_pipe = {exp_pipe[RD_LAT-2:0], e_grant};
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  logic [15:0] tr_a [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pipe = '0;
    transpose = 1'b0;
    max_row_count = '0;
    max_col_count = '0;
    we = 1'b0;
    re = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    g_name = "reset";
    do_reset();
    idle(2);

    // 66 x 2 matrix: rows 0..63 in bank 0, rows 64..65 in bank 1
    g_name = "write_map";
    max_row_count = 10'h041;
    max_col_count = 10'h001;
    for (int idx = 0; idx < 132; idx++) begin
      step(1'b1, 1'b0, map_sel(idx / 2), map_a(idx / 2, idx % 2), idx == 131, 1'b0);
    end
    step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    idle(1);

    // read stalled under writes, then granted from (0,0)
    g_name = "stall";
    do_reset();
    max_row_count = 10'd1;
    max_col_count = 10'd2;
    step(1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    idle(4);

    // 2 x 3 read with transpose requested; transpose dropped after the first read
    g_name = "transpose";
    do_reset();
`ifdef MATRIX_CTRL_TRANSPOSE_EN
    tr_a[0] = 16'h0000; tr_a[1] = 16'h0400; tr_a[2] = 16'h0001;
    tr_a[3] = 16'h0401; tr_a[4] = 16'h0002; tr_a[5] = 16'h0402;
`else
    tr_a[0] = 16'h0000; tr_a[1] = 16'h0001; tr_a[2] = 16'h0002;
    tr_a[3] = 16'h0400; tr_a[4] = 16'h0401; tr_a[5] = 16'h0402;
`endif
    max_row_count = 10'd1;
    max_col_count = 10'd2;
    transpose = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h0001, tr_a[i], 1'b0, i == 5);
      transpose = 1'b0;
    end
    step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    idle(4);

    // limit change mid-matrix waits for wrap
    g_name = "limit_latch";
    do_reset();
    max_row_count = 10'd1;
    max_col_count = 10'd3;
    step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    max_col_count = 10'd1;
    step(1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0400, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0401, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0402, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0403, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0400, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0001, 16'h0401, 1'b1, 1'b0);
    idle(1);

    // 1x1 matrix: every write is the last one
    g_name = "one_by_one";
    do_reset();
    max_row_count = 10'd0;
    max_col_count = 10'd0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0);
      idle(1);
    end

    // reset with two reads in flight drops their rd_valid
    g_name = "reset_mid_read";
    do_reset();
    max_row_count = 10'd1;
    max_col_count = 10'd2;
    step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    do_reset();
    idle(4);
    step(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
